// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and microword field layout for the microsequencer.
package cpu_pkg;
  localparam int UADDR_W = 8;
  localparam int UWORD_W = 27;
  localparam int CTRL_W = 16;
  localparam int NSEL_MSB = 26;
  localparam int NSEL_LSB = 24;
  localparam int TGT_MSB = 23;
  localparam int TGT_LSB = 16;
  localparam int CTRL_MSB = 15;
  localparam int CTRL_LSB = 0;
  typedef enum logic [2:0] {SEQ, JUMP, BRZ, BRC, BRN, DISPATCH, CALL, RET} next_sel_e;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
endpackage

// File: rtl/cpu_ustack.sv
// cpu_ustack: return-address LIFO with synchronous clear and full/empty status.
module cpu_ustack #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [SW-1:0] sp;
  assign full = sp == SW'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[AW'(sp - 1'b1)];
  always_ff @(posedge clk or posedge reset)
    if (reset) sp <= '0;
    else if (clear) sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop) sp <= sp - 1'b1;
  always_ff @(posedge clk)
    if (push) mem[AW'(sp)] <= din;
endmodule

// File: rtl/cpu_microsequencer.sv
// cpu_microsequencer: control-store sequencer computing the next microaddress
// and issuing datapath control bits from the current microword.
module cpu_microsequencer import cpu_pkg::*; #(
  parameter logic [UADDR_W-1:0] RESET_VEC = 8'd1,
  parameter logic [UADDR_W-1:0] DISPATCH_BASE = 8'd0,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic [7:0]         opcode,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic               flag_n,
  input  logic [UWORD_W-1:0] micro_word,
  output logic [UADDR_W-1:0] uaddr,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               running,
  output logic               halted,
  output logic               stack_err
);
  state_e state;
  next_sel_e nsel;
  logic [UADDR_W-1:0] tgt, seq, next, ret_addr;
  logic go, halt_word, push, pop, full, empty, stk_fault, start_ok;
  assign nsel = next_sel_e'(micro_word[NSEL_MSB:NSEL_LSB]);
  assign tgt = micro_word[TGT_MSB:TGT_LSB];
  assign seq = uaddr + 8'd1;
  assign go = state == RUN && !stall;
  assign halt_word = micro_word == '0;
  assign start_ok = start && state != RUN;
  assign push = go && nsel == CALL && !full;
  assign pop = go && nsel == RET && !empty;
  assign stk_fault = go && ((nsel == CALL && full) || (nsel == RET && empty));
  assign ctrl = go ? micro_word[CTRL_MSB:CTRL_LSB] : '0;
  assign running = state == RUN;
  assign halted = state == HALT;
  assign next = nsel == JUMP     ? tgt :
                nsel == BRZ      ? (flag_z ? tgt : seq) :
                nsel == BRC      ? (flag_c ? tgt : seq) :
                nsel == BRN      ? (flag_n ? tgt : seq) :
                nsel == DISPATCH ? DISPATCH_BASE + opcode :
                nsel == CALL     ? tgt :
                nsel == RET      ? ret_addr : seq;
  cpu_ustack #(.DEPTH(STACK_DEPTH), .W(UADDR_W)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(start_ok),
    .din(seq), .dout(ret_addr), .full(full), .empty(empty)
  );
  // A halting or faulting microword leaves uaddr parked on itself for debug.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      uaddr <= RESET_VEC;
      stack_err <= 1'b0;
    end else if (start_ok) begin
      state <= RUN;
      uaddr <= RESET_VEC;
      stack_err <= 1'b0;
    end else if (go) begin
      if (halt_word) state <= HALT;
      else if (stk_fault) begin
        state <= HALT;
        stack_err <= 1'b1;
      end else uaddr <= next;
    end
endmodule
